// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding and grant-width helper for the Wishbone arbiters
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Width of a master index; a single master still needs one bit to name it.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority pick: first requester after last, wrapping modulo NMASTERS
module rr_pick #(
  parameter int NMASTERS = 2,
  parameter int GRANT_W  = 1
) (
  input  logic [NMASTERS-1:0] req,
  input  logic [GRANT_W-1:0]  last,
  output logic [GRANT_W-1:0]  idx,
  output logic                valid
);

  int best_d;
  int d;

  // Each requester's distance past last; the smallest distance wins, so no power-of-two assumption.
  always_comb begin
    idx    = '0;
    best_d = NMASTERS;
    d      = 0;
    for (int j = 0; j < NMASTERS; j++) begin
      d = (j + 2 * NMASTERS - int'(last) - 1) % NMASTERS;
      if (req[j] && d < best_d) begin
        best_d = d;
        idx    = GRANT_W'(j);
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// rtl/wb_arbiter_rr.sv - N-master round-robin Wishbone classic arbiter; optional watchdog via WB_ARB_TIMEOUT_EN
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int NMASTERS       = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  input  logic [ADDR_WIDTH*NMASTERS-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH*NMASTERS-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH*NMASTERS-1:0]   wbm_dat_o,
  input  logic [NMASTERS-1:0]              wbm_we_i,
  input  logic [SELECT_WIDTH*NMASTERS-1:0] wbm_sel_i,
  input  logic [NMASTERS-1:0]              wbm_stb_i,
  input  logic [NMASTERS-1:0]              wbm_cyc_i,
  output logic [NMASTERS-1:0]              wbm_ack_o,
  output logic [NMASTERS-1:0]              wbm_err_o,
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]            wbs_dat_i,
  output logic                             wbs_we_o,
  output logic [SELECT_WIDTH-1:0]          wbs_sel_o,
  output logic                             wbs_stb_o,
  output logic                             wbs_cyc_o,
  input  logic                             wbs_ack_i,
  input  logic                             wbs_err_i
);

  localparam int GRANT_W = grant_w(NMASTERS);

  arb_state_t               state_q, state_d;
  logic [GRANT_W-1:0]       grant_q, grant_d;
  logic [GRANT_W-1:0]       last_q, last_d;
  logic [GRANT_W-1:0]       pick_idx;
  logic                     pick_valid;
  logic                     busy;
  logic                     gnt_cyc, gnt_stb, gnt_we;
  logic [ADDR_WIDTH-1:0]    gnt_adr;
  logic [DATA_WIDTH-1:0]    gnt_dat;
  logic [SELECT_WIDTH-1:0]  gnt_sel;
  logic                     kill;
  logic                     err_pulse;

  rr_pick #(
    .NMASTERS (NMASTERS),
    .GRANT_W  (GRANT_W)
  ) u_pick (
    .req   (wbm_cyc_i),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign busy = (state_q == ST_BUSY);

  always_comb begin
    gnt_cyc = 1'b0;
    gnt_stb = 1'b0;
    gnt_we  = 1'b0;
    gnt_adr = '0;
    gnt_dat = '0;
    gnt_sel = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (grant_q == GRANT_W'(k)) begin
        gnt_cyc = wbm_cyc_i[k];
        gnt_stb = wbm_stb_i[k];
        gnt_we  = wbm_we_i[k];
        gnt_adr = wbm_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        gnt_dat = wbm_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
        gnt_sel = wbm_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
      end
    end
  end

  // cyc tracks the granted master combinationally so the slave cycle ends the moment the master lets go.
  assign wbs_cyc_o = busy & gnt_cyc & ~kill;
  assign wbs_stb_o = busy & gnt_stb & ~kill;
  assign wbs_we_o  = busy & gnt_we;
  assign wbs_adr_o = busy ? gnt_adr : '0;
  assign wbs_dat_o = busy ? gnt_dat : '0;
  assign wbs_sel_o = busy ? gnt_sel : '0;
  assign wbm_dat_o = {NMASTERS{wbs_dat_i}};

  always_comb begin
    wbm_ack_o = '0;
    wbm_err_o = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      if (busy && grant_q == GRANT_W'(k)) begin
        wbm_ack_o[k] = wbs_ack_i;
        wbm_err_o[k] = wbs_err_i | err_pulse;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!gnt_cyc) begin
          state_d = ST_IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GRANT_W'(NMASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             kill_q;
  logic             err_q;
  logic             fire;

  assign fire = busy && wbs_stb_o && !wbs_ack_i && !wbs_err_i &&
                (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // kill stays set until the master abandons the cycle, keeping the slave off a dead transfer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cnt_q  <= '0;
      kill_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (!busy || wbs_ack_i || wbs_err_i || fire) cnt_q <= '0;
      else if (wbs_stb_o)                          cnt_q <= cnt_q + 1'b1;
      err_q <= fire;
      if (!busy)     kill_q <= 1'b0;
      else if (fire) kill_q <= 1'b1;
    end
  end

  assign kill      = kill_q;
  assign err_pulse = err_q;
`else
  assign kill      = 1'b0;
  assign err_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// tb/tb_wb_arbiter_rr.sv - directed self-checking bench for wb_arbiter_rr with two masters
module tb_wb_arbiter_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] m_adr, m_dat, m_dat_o;
  logic [1:0]  m_we, m_stb, m_cyc, m_ack, m_err;
  logic [7:0]  m_sel;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_we, s_stb, s_cyc, s_ack, s_err;
  logic [3:0]  s_sel;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter_rr #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .NMASTERS       (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbm_adr_i  (m_adr),
    .wbm_dat_i  (m_dat),
    .wbm_dat_o  (m_dat_o),
    .wbm_we_i   (m_we),
    .wbm_sel_i  (m_sel),
    .wbm_stb_i  (m_stb),
    .wbm_cyc_i  (m_cyc),
    .wbm_ack_o  (m_ack),
    .wbm_err_o  (m_err),
    .wbs_adr_o  (s_adr),
    .wbs_dat_o  (s_dat_o),
    .wbs_dat_i  (s_dat_i),
    .wbs_we_o   (s_we),
    .wbs_sel_o  (s_sel),
    .wbs_stb_o  (s_stb),
    .wbs_cyc_o  (s_cyc),
    .wbs_ack_i  (s_ack),
    .wbs_err_i  (s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    m_adr   = {32'h0000_0200, 32'h0000_0100};
    m_dat   = '0;
    m_we    = '0;
    m_stb   = '0;
    m_cyc   = '0;
    m_sel   = 8'hff;
    s_dat_i = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Grant of master k from an IDLE cycle, one acked transfer, release, dead cycle, re-request.
  task automatic serve(input int k);
    tick();
    chk("serve_cyc", 64'(s_cyc), 64'd1);
    chk("serve_adr", 64'(s_adr), (k == 1) ? 64'h200 : 64'h100);
    s_ack = 1'b1;
    #1;
    chk("serve_ack_route", 64'(m_ack), 64'(1) << k);
    tick();
    s_ack    = 1'b0;
    m_cyc[k] = 1'b0;
    m_stb[k] = 1'b0;
    #1;
    chk("serve_cyc_follows_drop", 64'(s_cyc), 64'd0);
    tick();
    m_cyc[k] = 1'b1;
    m_stb[k] = 1'b1;
    #1;
    chk("serve_dead_cycle", 64'(s_cyc), 64'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_cyc", 64'(s_cyc), 64'd0);
    chk("rst_ack", 64'(m_ack), 64'd0);
    chk("rst_err", 64'(m_err), 64'd0);
    tick();
    rst_n = 1'b1;

    // Master 0 alone reads 0x10
    m_adr[31:0] = 32'h0000_0010;
    m_cyc[0]    = 1'b1;
    m_stb[0]    = 1'b1;
    #1;
    chk("t1_latency_idle", 64'(s_cyc), 64'd0);
    tick();
    chk("t1_cyc", 64'(s_cyc), 64'd1);
    chk("t1_adr", 64'(s_adr), 64'h10);
    s_ack   = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", 64'(m_ack), 64'b01);
    chk("t1_dat_m0", 64'(m_dat_o[31:0]), 64'hDEAD_BEEF);
    chk("t1_dat_bcast", 64'(m_dat_o[63:32]), 64'hDEAD_BEEF);
    tick();
    s_ack    = 1'b0;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    #1;
    chk("t1_cyc_drop", 64'(s_cyc), 64'd0);
    tick();

    // Simultaneous requests after reset, then alternating grants
    do_reset();
    m_cyc = 2'b11;
    m_stb = 2'b11;
    serve(0);
    serve(1);
    serve(0);

    // Async reset while master 1 holds the bus
    tick();
    chk("t4_m1_granted", 64'(s_adr), 64'h200);
    #2;
    rst_n = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("t4_async_cyc", 64'(s_cyc), 64'd0);
    chk("t4_async_ack", 64'(m_ack), 64'd0);
    s_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_m0_after_rst", 64'(s_adr), 64'h100);

    // Master 1 write; master 0 inputs differ and must not leak through
    s_ack = 1'b1;
    tick();
    s_ack    = 1'b0;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    tick();
    m_cyc[0]        = 1'b1;
    m_stb[0]        = 1'b1;
    m_we            = 2'b10;
    m_sel           = 8'h3F;
    m_dat           = {32'h1234_5678, 32'hAAAA_AAAA};
    tick();
    chk("t5_sel", 64'(s_sel), 64'h3);
    chk("t5_dat", 64'(s_dat_o), 64'h1234_5678);
    chk("t5_we", 64'(s_we), 64'd1);
    s_err = 1'b1;
    #1;
    chk("t5_err_route", 64'(m_err), 64'b10);
    chk("t5_no_ack", 64'(m_ack), 64'd0);
    tick();
    s_err    = 1'b0;
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    m_we     = 2'b00;
    tick();

    // Master 0 granted, slave never answers
    tick();
    chk("t6_granted", 64'(s_cyc), 64'd1);
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("t6_stall_err", 64'(m_err), 64'd0);
      chk("t6_stall_cyc", 64'(s_cyc), 64'd1);
    end
    tick();
    chk("t6_timeout_err", 64'(m_err), 64'b01);
    chk("t6_timeout_cyc", 64'(s_cyc), 64'd0);
    tick();
    chk("t6_err_one_cycle", 64'(m_err), 64'd0);
    chk("t6_cyc_held_low", 64'(s_cyc), 64'd0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("t6_no_err", 64'(m_err), 64'd0);
    end
    chk("t6_still_stalled", 64'(s_cyc), 64'd1);
`endif
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    #1;
    chk("t6_release", 64'(s_cyc), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
